// File: rtl/char_collision.sv
// Per-frame ground and hit detection with a req/ack damage handshake and i-frame cooldown.
// Optional knock_dir/knock_valid outputs under CHAR_COLLISION_KNOCKBACK_EN.
module char_collision #(
  parameter int IFRAMES     = 60,
  parameter int GND_TOL     = 2,
  parameter int ACK_TIMEOUT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic [1:0]  game_active,
  input  logic [11:0] char_x,
  input  logic [11:0] char_y,
  input  logic [11:0] char_lng,
  input  logic [11:0] char_hgt,
  input  logic [3:0]  char_hp,
  input  logic [11:0] ground_lvl,
  input  logic [11:0] boss_x,
  input  logic [11:0] boss_y,
  input  logic [11:0] boss_lng,
  input  logic [11:0] boss_hgt,
  input  logic        hit_ack,
  output logic        on_ground,
  output logic        hit_req,
  output logic        iframe_active,
  output logic [7:0]  hit_count
`ifdef CHAR_COLLISION_KNOCKBACK_EN
  ,
  output logic        knock_dir,
  output logic        knock_valid
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    REQ,
    COOL
  } state_t;

  typedef struct packed {
    logic [11:0] cx;
    logic [11:0] cy;
    logic [11:0] cl;
    logic [11:0] ch;
    logic [11:0] gl;
    logic [11:0] bx;
    logic [11:0] by;
    logic [11:0] bl;
    logic [11:0] bh;
    logic [3:0]  hp;
  } snap_t;

  state_t      state_q, state_d;
  snap_t       snap_q;
  logic [7:0]  cool_q, cool_d;
  logic [7:0]  tmo_q, tmo_d;
  logic        og_ld, og_val;
  logic        acked;
  logic        playing;
  logic        ovl;
  logic        nz;
  logic [12:0] c_r, c_b, b_r, b_b;

  assign playing = (game_active == 2'd1);

  // 14 bits so bottom + tolerance cannot wrap either
  function automatic logic grounded(
    input logic [11:0] y,
    input logic [11:0] h,
    input logic [11:0] g
  );
    logic [13:0] s;
    s = 14'(y) + 14'(h) + 14'(GND_TOL);
    return s >= 14'(g);
  endfunction

  assign c_r = {1'b0, snap_q.cx} + {1'b0, snap_q.cl};
  assign c_b = {1'b0, snap_q.cy} + {1'b0, snap_q.ch};
  assign b_r = {1'b0, snap_q.bx} + {1'b0, snap_q.bl};
  assign b_b = {1'b0, snap_q.by} + {1'b0, snap_q.bh};

  assign nz = (snap_q.cl != 12'd0) && (snap_q.ch != 12'd0) &&
              (snap_q.bl != 12'd0) && (snap_q.bh != 12'd0);

  assign ovl = nz &&
               ({1'b0, snap_q.cx} < b_r) &&
               ({1'b0, snap_q.bx} < c_r) &&
               ({1'b0, snap_q.cy} < b_b) &&
               ({1'b0, snap_q.by} < c_b);

  always_comb begin
    state_d = state_q;
    cool_d  = cool_q;
    tmo_d   = tmo_q;
    og_ld   = 1'b0;
    og_val  = 1'b0;
    acked   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (frame_tick) state_d = CHECK;
      end
      CHECK: begin
        og_ld  = 1'b1;
        og_val = grounded(snap_q.cy, snap_q.ch, snap_q.gl);
        if (ovl && playing && snap_q.hp != 4'd0)
          state_d = REQ;
        else if (cool_q != 8'd0)
          state_d = COOL;
        else
          state_d = IDLE;
      end
      REQ: begin
        if (hit_ack) begin
          acked   = 1'b1;
          tmo_d   = 8'd0;
          cool_d  = 8'(IFRAMES);
          state_d = COOL;
        end else if (frame_tick) begin
          if (tmo_q >= 8'(ACK_TIMEOUT - 1)) begin
            tmo_d   = 8'd0;
            state_d = IDLE;
          end else begin
            tmo_d = tmo_q + 8'd1;
          end
        end
      end
      COOL: begin
        if (frame_tick) begin
          og_ld  = 1'b1;
          og_val = grounded(char_y, char_hgt, ground_lvl);
          if (cool_q <= 8'd1) begin
            cool_d  = 8'd0;
            state_d = IDLE;
          end else begin
            cool_d = cool_q - 8'd1;
          end
        end
      end
    endcase
    // leaving play aborts any pending hit or cooldown; ground keeps tracking
    if (!playing && (state_q == REQ || state_q == COOL)) begin
      state_d = IDLE;
      cool_d  = 8'd0;
      tmo_d   = 8'd0;
      acked   = 1'b0;
    end
  end

  assign hit_req       = (state_q == REQ) && playing;
  assign iframe_active = (state_q == COOL) && playing;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      snap_q    <= '0;
      cool_q    <= 8'd0;
      tmo_q     <= 8'd0;
      on_ground <= 1'b0;
      hit_count <= 8'd0;
    end else begin
      state_q <= state_d;
      cool_q  <= cool_d;
      tmo_q   <= tmo_d;
      if (og_ld) on_ground <= og_val;
      if (state_q == IDLE && frame_tick) begin
        snap_q <= '{cx: char_x, cy: char_y, cl: char_lng,
                    ch: char_hgt, gl: ground_lvl, bx: boss_x,
                    by: boss_y, bl: boss_lng, bh: boss_hgt,
                    hp: char_hp};
      end
      if (acked && hit_count != 8'hff)
        hit_count <= hit_count + 8'd1;
    end
  end

`ifdef CHAR_COLLISION_KNOCKBACK_EN
  logic [12:0] c_mid, b_mid;

  assign c_mid = {1'b0, snap_q.cx} + {2'b0, snap_q.cl[11:1]};
  assign b_mid = {1'b0, snap_q.bx} + {2'b0, snap_q.bl[11:1]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      knock_dir   <= 1'b0;
      knock_valid <= 1'b0;
    end else begin
      knock_valid <= acked;
      if (acked) knock_dir <= (c_mid >= b_mid);
    end
  end
`endif

endmodule

// File: tb/tb_char_collision.sv
// Directed bench for char_collision: ground, hit handshake, cooldown,
// edge touch, timeout, abort and async reset.
module tb_char_collision;

  logic        clk = 1'b0;
  logic        rst;
  logic        frame_tick;
  logic [1:0]  game_active;
  logic [11:0] char_x, char_y, char_lng, char_hgt;
  logic [3:0]  char_hp;
  logic [11:0] ground_lvl;
  logic [11:0] boss_x, boss_y, boss_lng, boss_hgt;
  logic        hit_ack;
  logic        on_ground, hit_req, iframe_active;
  logic [7:0]  hit_count;

  int vectors = 0;
  int errs    = 0;

  always #5 clk = ~clk;

  char_collision #(
    .IFRAMES(3),
    .GND_TOL(2),
    .ACK_TIMEOUT(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .frame_tick(frame_tick),
    .game_active(game_active),
    .char_x(char_x),
    .char_y(char_y),
    .char_lng(char_lng),
    .char_hgt(char_hgt),
    .char_hp(char_hp),
    .ground_lvl(ground_lvl),
    .boss_x(boss_x),
    .boss_y(boss_y),
    .boss_lng(boss_lng),
    .boss_hgt(boss_hgt),
    .hit_ack(hit_ack),
    .on_ground(on_ground),
    .hit_req(hit_req),
    .iframe_active(iframe_active),
    .hit_count(hit_count)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tick();
    @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  initial begin
    rst         = 1'b0;
    frame_tick  = 1'b0;
    game_active = 2'd1;
    char_x      = 12'd100;
    char_y      = 12'd400;
    char_lng    = 12'd32;
    char_hgt    = 12'd48;
    char_hp     = 4'd3;
    ground_lvl  = 12'd449;
    boss_x      = 12'd1000;
    boss_y      = 12'd420;
    boss_lng    = 12'd50;
    boss_hgt    = 12'd60;
    hit_ack     = 1'b0;
    #2;
    check("rst_on_ground", 32'(on_ground), 32'd0);
    check("rst_hit_req", 32'(hit_req), 32'd0);
    check("rst_iframe", 32'(iframe_active), 32'd0);
    check("rst_hit_count", 32'(hit_count), 32'd0);
    step(1);
    rst = 1'b1;
    step(1);

    // ground: 400+48+2=450 >= 449
    tick(); step(1);
    check("gnd_y400", 32'(on_ground), 32'd1);
    check("gnd_no_hit", 32'(hit_req), 32'd0);
    char_y = 12'd398;
    tick(); step(1);
    check("gnd_y398", 32'(on_ground), 32'd0);
    char_y = 12'd399;
    tick(); step(1);
    check("gnd_y399_edge", 32'(on_ground), 32'd1);
    char_y = 12'd400;

    // 1 px overlap
    boss_x = 12'd131;
    tick(); step(1);
    check("hit_req_rise", 32'(hit_req), 32'd1);
    step(4);
    check("hit_req_held", 32'(hit_req), 32'd1);
    hit_ack = 1'b1;
    step(1);
    hit_ack = 1'b0;
    check("ack_drop", 32'(hit_req), 32'd0);
    check("ack_iframe", 32'(iframe_active), 32'd1);
    check("ack_count1", 32'(hit_count), 32'd1);

    // cooldown of 3 frames with overlap held
    tick();
    check("cool_f1", 32'(iframe_active), 32'd1);
    check("cool_f1_req", 32'(hit_req), 32'd0);
    tick();
    check("cool_f2", 32'(iframe_active), 32'd1);
    tick();
    check("cool_f3_end", 32'(iframe_active), 32'd0);
    tick(); step(1);
    check("rehit_req", 32'(hit_req), 32'd1);
    hit_ack = 1'b1;
    step(1);
    hit_ack = 1'b0;
    check("ack_count2", 32'(hit_count), 32'd2);
    check("ack2_iframe", 32'(iframe_active), 32'd1);

    // abort during cooldown
    game_active = 2'd2;
    #1;
    check("abort_iframe", 32'(iframe_active), 32'd0);
    check("abort_req", 32'(hit_req), 32'd0);
    step(1);
    game_active = 2'd1;
    #1;
    check("abort_idle", 32'(iframe_active), 32'd0);
    check("abort_count", 32'(hit_count), 32'd2);

    // ack outside REQ ignored
    step(1);
    hit_ack = 1'b1;
    step(1);
    hit_ack = 1'b0;
    check("stray_ack", 32'(hit_count), 32'd2);

    // edges touching: 100+32 == 132
    boss_x = 12'd132;
    for (int i = 0; i < 10; i++) begin
      tick(); step(1);
      check("touch_no_hit", 32'(hit_req), 32'd0);
    end

    // zero HP and zero-size box never hit
    boss_x  = 12'd131;
    char_hp = 4'd0;
    tick(); step(1);
    check("hp0_no_hit", 32'(hit_req), 32'd0);
    char_hp  = 4'd3;
    char_x   = 12'd140;
    char_lng = 12'd0;
    tick(); step(1);
    check("zero_lng_no_hit", 32'(hit_req), 32'd0);
    char_x   = 12'd100;
    char_lng = 12'd32;

    // timeout after 4 unacked frames
    tick(); step(1);
    check("tmo_req", 32'(hit_req), 32'd1);
    tick();
    check("tmo_f1", 32'(hit_req), 32'd1);
    tick();
    check("tmo_f2", 32'(hit_req), 32'd1);
    tick();
    check("tmo_f3", 32'(hit_req), 32'd1);
    tick();
    check("tmo_drop", 32'(hit_req), 32'd0);
    check("tmo_count", 32'(hit_count), 32'd2);
    check("tmo_no_iframe", 32'(iframe_active), 32'd0);

    // async reset mid-REQ
    tick(); step(1);
    check("pre_rst_req", 32'(hit_req), 32'd1);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("arst_req", 32'(hit_req), 32'd0);
    check("arst_count", 32'(hit_count), 32'd0);
    check("arst_gnd", 32'(on_ground), 32'd0);
    check("arst_iframe", 32'(iframe_active), 32'd0);
    step(1);
    rst = 1'b1;
    tick(); step(1);
    check("post_rst_req", 32'(hit_req), 32'd1);
    check("post_rst_gnd", 32'(on_ground), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
